shuffle_unit: RTL and testbench

Store-path shuffler for the VLSU. It takes sequential data beats from the sequential-load stage and permutes them by element width (SEW) into the lane-interleaved register layout. It splits each beat into NrLanes per-lane beats and sends them to the lane entry ports, each lane with its own handshake. A per-request info queue holds SEW, request id and beat count; the queue entry retires when the final beat of the request has been accepted.

---
 rtl/shuffle_unit.sv | 130 +++++++++++++
 tb/tb_shuffle_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shuffle_unit.sv
// Store-path shuffler: permutes sequential beats by SEW into the lane-interleaved layout
// and hands each lane its slice with an independent handshake.
module shuffle_unit #(
    parameter int unsigned NrLanes    = 4,
    parameter int unsigned DLEN       = 64,
    parameter int unsigned ShfInfoDep = 4,
    parameter int unsigned CntBits    = 8,
    parameter int unsigned IdBits     = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        meta_valid_i,
    output logic                        meta_ready_o,
    input  logic [1:0]                  meta_sew_i,
    input  logic [CntBits-1:0]          meta_cmt_cnt_i,
    input  logic [IdBits-1:0]           meta_req_id_i,
    input  logic                        rx_seq_valid_i,
    output logic                        rx_seq_ready_o,
    input  logic [NrLanes*DLEN-1:0]     rx_seq_data_i,
    input  logic [NrLanes*DLEN/4-1:0]   rx_seq_en_i,
    output logic [NrLanes-1:0]          txs_valid_o,
    input  logic [NrLanes-1:0]          txs_ready_i,
    output logic [NrLanes*DLEN-1:0]     txs_data_o,
    output logic [NrLanes*DLEN/4-1:0]   txs_nbe_o,
    output logic [NrLanes-1:0]          txs_last_o,
    output logic [IdBits-1:0]           txs_req_id_o,
    output logic                        req_done_o,
    output logic [IdBits-1:0]           req_done_id_o
);

    localparam int unsigned DataW   = NrLanes * DLEN;
    localparam int unsigned NibW    = DataW / 4;
    localparam int unsigned LaneNib = DLEN / 4;
    localparam int unsigned PtrW    = $clog2(ShfInfoDep);
    localparam logic [PtrW:0] PtrOne = 1;
    localparam logic [CntBits-1:0] CntOne = 1;

    // Info queue; the pointer MSB is the wrap flag.
    logic [1:0]         info_sew_q [ShfInfoDep];
    logic [CntBits-1:0] info_cnt_q [ShfInfoDep];
    logic [IdBits-1:0]  info_id_q  [ShfInfoDep];
    logic [PtrW:0]      wr_ptr_q, rd_ptr_q;

    logic [PtrW-1:0]    wr_idx, rd_idx;
    logic               full, empty;
    logic [1:0]         head_sew;
    logic [CntBits-1:0] head_cnt;
    logic [IdBits-1:0]  head_id;
    logic               head_final;
    logic               enq, accept, deq, drain_ok;

    logic [NrLanes-1:0] valid_q, last_q;
    logic [DataW-1:0]   data_q;
    logic [NibW-1:0]    nbe_q;
    logic [IdBits-1:0]  id_q;

    logic [3:0][DataW-1:0] perm_data;
    logic [3:0][NibW-1:0]  perm_en;

    assign wr_idx     = wr_ptr_q[PtrW-1:0];
    assign rd_idx     = rd_ptr_q[PtrW-1:0];
    assign full       = (wr_idx == rd_idx) && (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]);
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign head_sew   = info_sew_q[rd_idx];
    assign head_cnt   = info_cnt_q[rd_idx];
    assign head_id    = info_id_q[rd_idx];
    assign head_final = (head_cnt == '0);

    assign drain_ok = &(~valid_q | txs_ready_i);
    assign enq      = meta_valid_i && !full;
    assign accept   = rx_seq_valid_i && rx_seq_ready_o;
    assign deq      = accept && head_final;

    assign meta_ready_o   = !full;
    assign rx_seq_ready_o = !empty && drain_ok;

    // Static permutation per SEW, written as the inverse map: lane nibble -> source nibble.
    for (genvar s = 0; s < 4; s++) begin : g_sew
        for (genvar l = 0; l < NrLanes; l++) begin : g_lane
            for (genvar t = 0; t < LaneNib; t++) begin : g_nib
                localparam int unsigned Src =
                    ((((t >> (s + 1)) * NrLanes) + l) << (s + 1)) + (t & ((2 << s) - 1));
                assign perm_data[s][(l*LaneNib+t)*4 +: 4] = rx_seq_data_i[Src*4 +: 4];
                assign perm_en[s][l*LaneNib+t]            = rx_seq_en_i[Src];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= '0;
            last_q   <= '0;
        end else begin
            if (enq) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (deq) rd_ptr_q <= rd_ptr_q + PtrOne;
            // A fresh accept overrides any per-lane clear in the same cycle.
            if (accept) begin
                valid_q <= '1;
                last_q  <= {NrLanes{head_final}};
            end else begin
                valid_q <= valid_q & ~txs_ready_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            info_sew_q[wr_idx] <= meta_sew_i;
            info_cnt_q[wr_idx] <= meta_cmt_cnt_i;
            info_id_q[wr_idx]  <= meta_req_id_i;
        end
        if (accept) begin
            if (!head_final) info_cnt_q[rd_idx] <= head_cnt - CntOne;
            data_q <= perm_data[head_sew];
            nbe_q  <= perm_en[head_sew];
            id_q   <= head_id;
        end
    end

    assign txs_valid_o   = valid_q;
    assign txs_data_o    = data_q;
    assign txs_nbe_o     = nbe_q;
    assign txs_last_o    = last_q;
    assign txs_req_id_o  = id_q;
    assign req_done_o    = last_q[0] && (valid_q != '0) && ((valid_q & ~txs_ready_i) == '0);
    assign req_done_id_o = id_q;

endmodule

// File: tb/tb_shuffle_unit.sv
// Self-checking bench for shuffle_unit: directed scenarios plus a randomized run against
// a scoreboard that applies the element/lane mapping arithmetically.
module tb_shuffle_unit;

    localparam int NL  = 4;
    localparam int NW  = 64;
    localparam int DEP = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         meta_valid, meta_ready;
    logic [1:0]   meta_sew;
    logic [7:0]   meta_cnt;
    logic [3:0]   meta_id;
    logic         rx_valid, rx_ready;
    logic [255:0] rx_data;
    logic [63:0]  rx_en;
    logic [3:0]   txs_valid, txs_ready, txs_last, txs_id, done_id;
    logic [255:0] txs_data;
    logic [63:0]  txs_nbe;
    logic         req_done;

    always #5 clk = ~clk;

    shuffle_unit #(
        .NrLanes(4), .DLEN(64), .ShfInfoDep(4), .CntBits(8), .IdBits(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .meta_valid_i(meta_valid), .meta_ready_o(meta_ready), .meta_sew_i(meta_sew),
        .meta_cmt_cnt_i(meta_cnt), .meta_req_id_i(meta_id),
        .rx_seq_valid_i(rx_valid), .rx_seq_ready_o(rx_ready), .rx_seq_data_i(rx_data),
        .rx_seq_en_i(rx_en),
        .txs_valid_o(txs_valid), .txs_ready_i(txs_ready), .txs_data_o(txs_data),
        .txs_nbe_o(txs_nbe), .txs_last_o(txs_last), .txs_req_id_o(txs_id),
        .req_done_o(req_done), .req_done_id_o(done_id)
    );

    typedef struct {
        logic [1:0] sew;
        int         cnt;
        logic [3:0] id;
    } req_t;

    req_t        mq[$];
    logic [3:0]  m_valid;
    logic [63:0] m_data [NL];
    logic [15:0] m_nbe  [NL];
    logic        m_last;
    logic [3:0]  m_id;

    int n_checks = 0, n_fail = 0;
    int obs_acc = 0, obs_enq = 0, obs_done = 0;
    logic [255:0] seq_bytes;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Element elem of SEW width goes to lane elem%NL at slot elem/NL.
    task automatic model_load(input logic [255:0] d, input logic [63:0] en, input logic [1:0] sew);
        int e, elem, sub, lane, tn;
        e = 2 << int'(sew);
        for (int n = 0; n < NW; n++) begin
            elem = n / e;
            sub  = n % e;
            lane = elem % NL;
            tn   = (elem / NL) * e + sub;
            m_data[lane][4*tn +: 4] = d[4*n +: 4];
            m_nbe[lane][tn]         = en[n];
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_valid = '0;
        m_last  = 1'b0;
    endtask

    // Inputs are set after a falling edge; check, advance the model, cross one rising edge.
    task automatic tick();
        logic drain, acc, enq, exp_done;
        req_t h;
        #1;
        drain = &(~m_valid | txs_ready);
        check("meta_ready", meta_ready, mq.size() < DEP);
        check("rx_ready", rx_ready, (mq.size() > 0) && drain);
        check("txs_valid", txs_valid, m_valid);
        for (int l = 0; l < NL; l++) begin
            if (m_valid[l]) begin
                check($sformatf("lane%0d_data", l), txs_data[64*l +: 64], m_data[l]);
                check($sformatf("lane%0d_nbe", l), txs_nbe[16*l +: 16], m_nbe[l]);
            end
        end
        if (m_valid != '0) begin
            check("txs_last", txs_last, {NL{m_last}});
            check("txs_id", txs_id, m_id);
        end
        exp_done = m_last && (m_valid != '0) && ((m_valid & ~txs_ready) == '0);
        check("req_done", req_done, exp_done);
        if (exp_done) check("req_done_id", done_id, m_id);
        if (req_done) obs_done++;
        if (rx_valid && rx_ready) obs_acc++;
        if (meta_valid && meta_ready) obs_enq++;

        acc = rx_valid && (mq.size() > 0) && drain;
        enq = meta_valid && (mq.size() < DEP);
        m_valid = m_valid & ~txs_ready;
        if (acc) begin
            h = mq[0];
            model_load(rx_data, rx_en, h.sew);
            m_valid = '1;
            m_last  = (h.cnt == 0);
            m_id    = h.id;
            if (h.cnt == 0) begin
                void'(mq.pop_front());
            end else begin
                h.cnt  = h.cnt - 1;
                mq[0] = h;
            end
        end
        if (enq) begin
            h.sew = meta_sew;
            h.cnt = int'(meta_cnt);
            h.id  = meta_id;
            mq.push_back(h);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic enqueue(input logic [1:0] sew, input logic [7:0] cnt, input logic [3:0] id);
        meta_valid = 1'b1;
        meta_sew   = sew;
        meta_cnt   = cnt;
        meta_id    = id;
        tick();
        meta_valid = 1'b0;
    endtask

    initial begin
        int a, e, d;
        for (int b = 0; b < 32; b++) seq_bytes[8*b +: 8] = 8'(b);
        rst_n = 1'b0; meta_valid = 1'b0; meta_sew = '0; meta_cnt = '0; meta_id = '0;
        rx_valid = 1'b0; rx_data = '0; rx_en = '1; txs_ready = '1;
        model_reset();
        #2;
        check("rst_meta_ready", meta_ready, 1'b1);
        check("rst_txs_valid", txs_valid, 4'h0);
        check("rst_txs_last", txs_last, 4'h0);
        check("rst_req_done", req_done, 1'b0);
        check("rst_rx_ready", rx_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Byte elements: lane l collects bytes l, l+4, l+8, ...
        enqueue(2'd0, 8'd0, 4'd3);
        rx_valid = 1'b1; rx_data = seq_bytes; rx_en = '1;
        tick();
        rx_valid = 1'b0;
        #1;
        check("t1_lane0", txs_data[63:0], 64'h1C1814100C080400);
        check("t1_lane1", txs_data[127:64], 64'h1D1915110D090501);
        check("t1_last", txs_last, 4'hF);
        d = obs_done;
        tick();
        tick();
        check("t1_done_pulses", obs_done - d, 1);

        // 64-bit elements pass straight through; lane 2 enables masked.
        enqueue(2'd3, 8'd0, 4'd5);
        rx_valid = 1'b1; rx_data = seq_bytes; rx_en = 64'hFFFF_0000_FFFF_FFFF;
        tick();
        rx_valid = 1'b0; rx_en = '1;
        #1;
        check("t2_lane2", txs_data[191:128], 64'h1716151413121110);
        check("t2_nbe", txs_nbe, 64'hFFFF_0000_FFFF_FFFF);
        tick();

        // Three-beat request, back to back.
        enqueue(2'd1, 8'd2, 4'd7);
        rx_valid = 1'b1;
        a = obs_acc;
        for (int k = 0; k < 3; k++) begin
            rx_data = {8{$urandom}};
            tick();
            #1;
            check($sformatf("t3_last_beat%0d", k), txs_last, (k == 2) ? 4'hF : 4'h0);
        end
        check("t3_accepts", obs_acc - a, 3);
        rx_valid = 1'b0;
        tick();

        // Lane 1 stalls three cycles.
        enqueue(2'd2, 8'd1, 4'd9);
        rx_valid = 1'b1; rx_data = {8{$urandom}};
        tick();
        txs_ready = 4'b1101;
        rx_data = {8{$urandom}};
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t4_stall_ready", rx_ready, 1'b0);
            tick();
        end
        #1;
        check("t4_valid_left", txs_valid, 4'b0010);
        txs_ready = 4'hF;
        a = obs_acc;
        tick();
        check("t4_resume_accept", obs_acc - a, 1);
        rx_valid = 1'b0;
        tick();

        // Fill the queue, then dequeue and enqueue together.
        for (int k = 1; k <= 4; k++) enqueue(2'd0, 8'd0, 4'(k));
        #1;
        check("t5_full", meta_ready, 1'b0);
        meta_valid = 1'b1; meta_sew = 2'd0; meta_cnt = 8'd0; meta_id = 4'd5;
        rx_valid = 1'b1; rx_data = {8{$urandom}};
        e = obs_enq;
        tick();
        check("t5_enq_rejected", obs_enq - e, 0);
        e = obs_enq;
        tick();
        check("t5_enq_accepted", obs_enq - e, 1);
        meta_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rx_data = {8{$urandom}};
            tick();
        end
        rx_valid = 1'b0;
        tick();

        // Reset while a beat is half drained.
        enqueue(2'd0, 8'd3, 4'd6);
        rx_valid = 1'b1; rx_data = {8{$urandom}};
        tick();
        rx_valid = 1'b0; txs_ready = 4'b0011;
        tick();
        rst_n = 1'b0;
        #1;
        check("t6_valid", txs_valid, 4'h0);
        check("t6_meta_ready", meta_ready, 1'b1);
        check("t6_req_done", req_done, 1'b0);
        model_reset();
        txs_ready = 4'hF;
        tick();
        rst_n = 1'b1;
        tick();

        // Randomized traffic.
        for (int c = 0; c < 500; c++) begin
            meta_valid = ($urandom % 3) == 0;
            meta_sew   = 2'($urandom);
            meta_cnt   = 8'($urandom % 4);
            meta_id    = 4'($urandom);
            rx_valid   = ($urandom % 4) != 0;
            rx_data    = {$urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, $urandom};
            rx_en      = {$urandom, $urandom};
            txs_ready  = 4'($urandom | $urandom);
            tick();
        end
        meta_valid = 1'b0; rx_valid = 1'b1; txs_ready = 4'hF;
        for (int c = 0; c < 40; c++) tick();
        rx_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
